wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter N_RINSE, default 2, number of water-rinse passes after the soap wash (0..7).
REQ-002 Parameter CNT_W, default 16, width of the internal phase timer.
REQ-003 Parameters WASH_TICKS 600, RINSE_TICKS 300, SPIN_TICKS 200: dwell of each timed phase, in ticks (each >=1).
REQ-004 Parameters FILL_LIMIT 120, DRAIN_LIMIT 120: tick budget before fill/drain is declared failed (each >=1).
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  one-cycle timebase enable; all timers advance only on tick.
REQ-008 start, door_close, filled, detergent_added, drained, pause  in  1 each  user/sensor levels.
REQ-009 door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash, spin_on  out  1 each  actuator/status levels.
REQ-010 done  out  1  one-cycle completion pulse; error  out  1  fault latched.
REQ-011 rinse_cnt  out  3  current rinse pass (0 = soap wash); state_o  out  3  current state code.

Function
REQ-012 States: IDLE, FILL, DETERGENT, WASH, DRAIN, SPIN, FAULT; one 3-bit registered state; outputs decoded combinationally from state, rinse_cnt, pause.
REQ-013 IDLE: door_lock=0, all actuators 0; start=1 and door_close=1 -> FILL with rinse_cnt cleared to 0; start otherwise ignored in every state.
REQ-014 FILL: fill_valve_on=1; filled=1 -> DETERGENT if rinse_cnt==0 else WASH.
REQ-015 FILL: on tick with timer==FILL_LIMIT-1 and filled=0 -> FAULT; filled=1 in the same cycle wins.
REQ-016 DETERGENT: actuators 0; detergent_added=1 -> WASH; no timeout.
REQ-017 WASH: motor_on=1; soap_wash=1 if rinse_cnt==0 else water_wash=1; leaves to DRAIN on tick with timer==WASH_TICKS-1 (soap) or RINSE_TICKS-1 (rinse), giving dwell of exactly that many ticks.
REQ-018 DRAIN: drain_valve_on=1; drained=1 -> if rinse_cnt<N_RINSE then rinse_cnt+1 and FILL, else SPIN; tick with timer==DRAIN_LIMIT-1 and drained=0 -> FAULT, drained wins ties.
REQ-019 N_RINSE=0: soap wash DRAIN goes directly to SPIN.
REQ-020 SPIN: motor_on=1, spin_on=1, drain_valve_on=1; tick with timer==SPIN_TICKS-1 -> IDLE with done=1 for exactly that transition cycle.
REQ-021 Timer cleared to 0 on every state change; increments on tick when not paused; never wraps (saturates at all-ones).
REQ-022 door_lock=1 in every state except IDLE and FAULT.
REQ-023 pause=1 in FILL/WASH/DRAIN/SPIN: state and timer frozen, motor/valve/spin outputs forced 0, door_lock stays 1, sensor-driven transitions suppressed; resumes same timer value on pause=0.
REQ-024 door_close=0 in any state other than IDLE/FAULT -> FAULT next cycle (locked-door violation), regardless of pause.
REQ-025 FAULT: error=1, drain_valve_on=1, all else 0, door_lock=0; exit only via reset.
REQ-026 Concurrent events priority: door violation > timeout fault > normal transition.

Reset
REQ-027 reset=0 forces state IDLE, timer 0, rinse_cnt 0 immediately, asynchronous to clk, from any state including mid-cycle.
REQ-028 During and after reset all outputs 0 (done=0, error=0, door_lock=0) until next start.
REQ-029 Reset release is synchronised internally; first state change no earlier than second clk edge after release.

Structure
REQ-030 Shared package wash_pkg holds state encodings (IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, FAULT=7) and default tick constants.
REQ-031 One sub-module wash_timer: CNT_W counter with clear, enable, saturate, terminal-compare output; instantiated once.
REQ-032 Elaboration check rejects N_RINSE>7 or any tick/limit parameter of 0.

Verification
REQ-033 N_RINSE=2, WASH_TICKS=4, RINSE_TICKS=2, SPIN_TICKS=3, all sensors prompt -> state sequence FILL,DET,WASH,DRAIN,(FILL,WASH,DRAIN)x2,SPIN,IDLE; soap_wash 4 ticks, water_wash 2 ticks each; one done pulse.
REQ-034 FILL_LIMIT=5, filled held 0 -> FAULT after 5th tick, error=1, door_lock=0; filled=1 on 5th tick -> no fault.
REQ-035 pause=1 for 10 ticks mid-WASH at timer=2 -> motor_on=0, timer holds 2; after release WASH lasts remaining ticks.
REQ-036 door_close=0 during SPIN -> FAULT next cycle, motor_on=0, drain_valve_on=1.
REQ-037 reset=0 asserted mid-DRAIN between clk edges -> outputs 0 before next edge; rinse_cnt=0.
REQ-038 N_RINSE=0 -> single WASH then SPIN, water_wash never asserted.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared state encodings, default timing constants and state-class helpers
// for the wash sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_DETERGENT = 3'd2,
    ST_WASH      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_SPIN      = 3'd5,
    ST_FAULT     = 3'd7
  } state_t;

  localparam int DEF_N_RINSE     = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WASH_TICKS  = 600;
  localparam int DEF_RINSE_TICKS = 300;
  localparam int DEF_SPIN_TICKS  = 200;
  localparam int DEF_FILL_LIMIT  = 120;
  localparam int DEF_DRAIN_LIMIT = 120;

  localparam int RST_SYNC_STAGES = 2;

  // The door must stay locked whenever the drum may hold water or move.
  function automatic logic is_locked(input state_t s);
    return (s != ST_IDLE) && (s != ST_FAULT);
  endfunction

  function automatic logic is_pausable(input state_t s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wash_timer.sv
// Phase timer: clears on request, counts enabled ticks, saturates at
// all-ones and flags when the count equals the selected terminal value.
module wash_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             saturated;

  assign saturated = &count_reg;
  assign at_term   = (count_reg == term);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !saturated) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine phase sequencer: fill, detergent, wash, drain, rinse
// passes and spin, with pause, door interlock and fill/drain timeouts.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int N_RINSE     = DEF_N_RINSE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WASH_TICKS  = DEF_WASH_TICKS,
  parameter int RINSE_TICKS = DEF_RINSE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
  parameter int FILL_LIMIT  = DEF_FILL_LIMIT,
  parameter int DRAIN_LIMIT = DEF_DRAIN_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       door_close,
  input  logic       filled,
  input  logic       detergent_added,
  input  logic       drained,
  input  logic       pause,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       spin_on,
  output logic       done,
  output logic       error,
  output logic [2:0] rinse_cnt,
  output logic [2:0] state_o
);

  if (N_RINSE < 0 || N_RINSE > 7 || CNT_W < 1 ||
      WASH_TICKS < 1 || RINSE_TICKS < 1 || SPIN_TICKS < 1 ||
      FILL_LIMIT < 1 || DRAIN_LIMIT < 1) begin : g_param_check
    $error("wash_sequencer: N_RINSE must be 0..7 and every tick/limit parameter >= 1");
  end

  localparam logic [2:0]       N_RINSE_3  = 3'(N_RINSE);
  localparam logic [CNT_W-1:0] FILL_TERM  = CNT_W'(FILL_LIMIT - 1);
  localparam logic [CNT_W-1:0] DRAIN_TERM = CNT_W'(DRAIN_LIMIT - 1);
  localparam logic [CNT_W-1:0] WASH_TERM  = CNT_W'(WASH_TICKS - 1);
  localparam logic [CNT_W-1:0] RINSE_TERM = CNT_W'(RINSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPIN_TERM  = CNT_W'(SPIN_TICKS - 1);

  // Reset asserts asynchronously but is released through a short shift
  // chain, so the FSM never sees a release close to a clock edge.
  logic [RST_SYNC_STAGES-1:0] rst_sync_reg;
  logic                       core_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_reg <= '0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync_reg[RST_SYNC_STAGES-1];

  state_t           state_reg;
  state_t           state_next;
  logic [2:0]       rinse_reg;
  logic [2:0]       rinse_next;
  logic [CNT_W-1:0] term_sel;
  logic             at_term;
  logic             running;
  logic             door_viol;
  logic             expired;
  logic             timer_clear;

  assign running     = !(pause && is_pausable(state_reg));
  assign door_viol   = is_locked(state_reg) && !door_close;
  assign expired     = tick && running && at_term;
  assign timer_clear = (state_next != state_reg);

  always_comb begin
    term_sel = '1;
    case (state_reg)
      ST_FILL:  term_sel = FILL_TERM;
      ST_WASH:  term_sel = (rinse_reg == 3'd0) ? WASH_TERM : RINSE_TERM;
      ST_DRAIN: term_sel = DRAIN_TERM;
      ST_SPIN:  term_sel = SPIN_TERM;
      default:  term_sel = '1;
    endcase
  end

  wash_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (core_rst_n),
    .clear   (timer_clear),
    .enable  (tick && running),
    .term    (term_sel),
    .at_term (at_term)
  );

  // A sensor arriving on the same tick as the timeout wins, because the
  // timeout branch is only reached when the sensor is still low.
  always_comb begin
    state_next = state_reg;
    rinse_next = rinse_reg;
    if (door_viol) begin
      state_next = ST_FAULT;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && door_close) begin
            state_next = ST_FILL;
            rinse_next = 3'd0;
          end
        end
        ST_FILL: begin
          if (running) begin
            if (filled) begin
              state_next = (rinse_reg == 3'd0) ? ST_DETERGENT : ST_WASH;
            end else if (expired) begin
              state_next = ST_FAULT;
            end
          end
        end
        ST_DETERGENT: begin
          if (detergent_added) begin
            state_next = ST_WASH;
          end
        end
        ST_WASH: begin
          if (expired) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (running) begin
            if (drained) begin
              if (rinse_reg < N_RINSE_3) begin
                rinse_next = rinse_reg + 3'd1;
                state_next = ST_FILL;
              end else begin
                state_next = ST_SPIN;
              end
            end else if (expired) begin
              state_next = ST_FAULT;
            end
          end
        end
        ST_SPIN: begin
          if (expired) begin
            state_next = ST_IDLE;
          end
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_reg <= ST_IDLE;
      rinse_reg <= 3'd0;
    end else begin
      state_reg <= state_next;
      rinse_reg <= rinse_next;
    end
  end

  // Pause silences motor and valves but leaves the wash-type status visible.
  always_comb begin
    door_lock      = is_locked(state_reg);
    motor_on       = 1'b0;
    fill_valve_on  = 1'b0;
    drain_valve_on = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    spin_on        = 1'b0;
    error          = 1'b0;
    done           = (state_reg == ST_SPIN) && expired && !door_viol;
    case (state_reg)
      ST_FILL: fill_valve_on = running;
      ST_WASH: begin
        motor_on   = running;
        soap_wash  = (rinse_reg == 3'd0);
        water_wash = (rinse_reg != 3'd0);
      end
      ST_DRAIN: drain_valve_on = running;
      ST_SPIN: begin
        motor_on       = running;
        spin_on        = running;
        drain_valve_on = running;
      end
      ST_FAULT: begin
        drain_valve_on = 1'b1;
        error          = 1'b1;
      end
      default: ;
    endcase
  end

  assign rinse_cnt = rinse_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Scenario bench for wash_sequencer: expected state sequences are queued at
// stimulus time and compared against transitions recorded by a monitor.
module tb_wash_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_DET = 3'd2, S_WASH = 3'd3,
                         S_DRAIN = 3'd4, S_SPIN = 3'd5, S_FAULT = 3'd7;

  logic clk = 1'b0;
  logic reset, tick, start, start0, door_close, filled, detergent_added, drained, pause;

  logic door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash, spin_on, done, error;
  logic [2:0] rinse_cnt, st;
  logic door_lock0, motor_on0, fill_valve_on0, drain_valve_on0, soap_wash0, water_wash0, spin_on0, done0, error0;
  logic [2:0] rinse_cnt0, st0;
  logic [8:0] outs, outs0;

  assign outs  = {door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash, water_wash, spin_on, done, error};
  assign outs0 = {door_lock0, motor_on0, fill_valve_on0, drain_valve_on0, soap_wash0, water_wash0, spin_on0, done0, error0};

  always #5 clk = ~clk;

  wash_sequencer #(.N_RINSE(2), .CNT_W(8), .WASH_TICKS(4), .RINSE_TICKS(2), .SPIN_TICKS(3),
                   .FILL_LIMIT(5), .DRAIN_LIMIT(5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .door_close(door_close),
    .filled(filled), .detergent_added(detergent_added), .drained(drained), .pause(pause),
    .door_lock(door_lock), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
    .drain_valve_on(drain_valve_on), .soap_wash(soap_wash), .water_wash(water_wash),
    .spin_on(spin_on), .done(done), .error(error), .rinse_cnt(rinse_cnt), .state_o(st));

  wash_sequencer #(.N_RINSE(0), .CNT_W(8), .WASH_TICKS(4), .RINSE_TICKS(2), .SPIN_TICKS(3),
                   .FILL_LIMIT(5), .DRAIN_LIMIT(5)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .start(start0), .door_close(door_close),
    .filled(filled), .detergent_added(detergent_added), .drained(drained), .pause(pause),
    .door_lock(door_lock0), .motor_on(motor_on0), .fill_valve_on(fill_valve_on0),
    .drain_valve_on(drain_valve_on0), .soap_wash(soap_wash0), .water_wash(water_wash0),
    .spin_on(spin_on0), .done(done0), .error(error0), .rinse_cnt(rinse_cnt0), .state_o(st0));

  int n_cmp = 0;
  int n_bad = 0;
  bit tick_ph = 1'b0;

  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] obs0_q[$];
  logic [2:0] prev_st = 3'd0;
  logic [2:0] prev_st0 = 3'd0;
  int soap_ticks = 0, water_ticks = 0, done_cnt = 0;
  int soap0_ticks = 0, water0_cnt = 0, done0_cnt = 0;

  // Monitor: records state changes and tallies status pulses, never judges.
  always @(negedge clk) begin
    if (st != prev_st) begin
      obs_q.push_back(st);
      prev_st = st;
    end
    if (st0 != prev_st0) begin
      obs0_q.push_back(st0);
      prev_st0 = st0;
    end
    if (soap_wash && tick) soap_ticks++;
    if (water_wash && tick) water_ticks++;
    if (done) done_cnt++;
    if (soap_wash0 && tick) soap0_ticks++;
    if (water_wash0) water0_cnt++;
    if (done0) done0_cnt++;
  end

  task automatic cycle(input bit t);
    tick = t;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle();
    tick_ph = !tick_ph;
    cycle(tick_ph);
  endtask

  task automatic apply_reset();
    tick = 1'b0; start = 1'b0; start0 = 1'b0; pause = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (st == s) begin
        ok = 1'b1;
        break;
      end
      run_cycle();
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: state %0d never reached, stuck at %0d", name, s, st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++; if (st !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", st, S_IDLE); end
    n_cmp++; if (outs !== 9'd0) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, 9'd0); end
    n_cmp++; if (outs0 !== 9'd0) begin n_bad++; $display("FAIL reset_outs0: got %b want %b", outs0, 9'd0); end
    n_cmp++; if (rinse_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_rinse: got %0d want 0", rinse_cnt); end
    @(posedge clk); #1;
    start = 1'b1; door_close = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (st !== S_IDLE) begin n_bad++; $display("FAIL sync_first_edge: got %0d want %0d", st, S_IDLE); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (st !== S_FILL) begin n_bad++; $display("FAIL start_after_sync: got %0d want %0d", st, S_FILL); end
    apply_reset();
    n_cmp++; if (st !== S_IDLE || error !== 1'b0) begin n_bad++; $display("FAIL rereset: state %0d error %b want 0/0", st, error); end
    $display("reset: state %0d outs %b", st, outs);
  endtask

  task automatic test_full_cycle();
    int s0, w0, d0;
    logic [2:0] e, o;
    logic [2:0] seq [12] = '{S_FILL, S_DET, S_WASH, S_DRAIN, S_FILL, S_WASH, S_DRAIN,
                             S_FILL, S_WASH, S_DRAIN, S_SPIN, S_IDLE};
    apply_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1; door_close = 1'b1;
    s0 = soap_ticks; w0 = water_ticks; d0 = done_cnt;
    exp_q.delete(); obs_q.delete();
    foreach (seq[i]) exp_q.push_back(seq[i]);
    start = 1'b1; run_cycle(); start = 1'b0;
    for (int i = 0; i < 300 && obs_q.size() < 12; i++) run_cycle();
    repeat (4) run_cycle();
    n_cmp++; if (obs_q.size() != 12) begin n_bad++; $display("FAIL full_len: got %0d want 12", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'd6;
      $display("full: state %0d expected %0d", o, e);
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL full_seq: got %0d want %0d", o, e); end
    end
    n_cmp++; if (soap_ticks - s0 != 4) begin n_bad++; $display("FAIL soap_ticks: got %0d want 4", soap_ticks - s0); end
    n_cmp++; if (water_ticks - w0 != 4) begin n_bad++; $display("FAIL water_ticks: got %0d want 4", water_ticks - w0); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_fill_timeout();
    apply_reset();
    filled = 1'b0; door_close = 1'b1;
    start = 1'b1; cycle(1'b0); start = 1'b0;
    repeat (4) begin cycle(1'b1); cycle(1'b0); end
    n_cmp++; if (st !== S_FILL) begin n_bad++; $display("FAIL fill_4ticks: got %0d want %0d", st, S_FILL); end
    cycle(1'b1);
    n_cmp++; if (st !== S_FAULT) begin n_bad++; $display("FAIL fill_timeout: got %0d want %0d", st, S_FAULT); end
    n_cmp++; if (outs !== 9'b000100001) begin n_bad++; $display("FAIL fault_outs: got %b want %b", outs, 9'b000100001); end
    start = 1'b1; repeat (4) run_cycle(); start = 1'b0;
    n_cmp++; if (st !== S_FAULT) begin n_bad++; $display("FAIL fault_sticky: got %0d want %0d", st, S_FAULT); end
    $display("fill_timeout: state %0d error %b", st, error);
    apply_reset();
    start = 1'b1; cycle(1'b0); start = 1'b0;
    repeat (4) begin cycle(1'b1); cycle(1'b0); end
    filled = 1'b1;
    cycle(1'b1);
    n_cmp++; if (st !== S_DET || error !== 1'b0) begin n_bad++; $display("FAIL fill_tie: state %0d error %b want %0d/0", st, error, S_DET); end
  endtask

  task automatic test_pause();
    int n;
    apply_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1; door_close = 1'b1;
    start = 1'b1; run_cycle(); start = 1'b0;
    wait_state(S_WASH, 50, "pause_reach_wash");
    repeat (2) begin cycle(1'b1); cycle(1'b0); end
    n_cmp++; if (motor_on !== 1'b1) begin n_bad++; $display("FAIL pause_motor_before: got %b want 1", motor_on); end
    pause = 1'b1;
    repeat (10) begin cycle(1'b1); cycle(1'b0); end
    n_cmp++; if (motor_on !== 1'b0 || door_lock !== 1'b1) begin n_bad++; $display("FAIL pause_outs: motor %b lock %b want 0/1", motor_on, door_lock); end
    n_cmp++; if (st !== S_WASH) begin n_bad++; $display("FAIL pause_state: got %0d want %0d", st, S_WASH); end
    n_cmp++; if (dut.u_timer.count_reg !== 8'd2) begin n_bad++; $display("FAIL pause_timer: got %0d want 2", dut.u_timer.count_reg); end
    pause = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1);
      n++;
      if (st != S_WASH) break;
      cycle(1'b0);
    end
    $display("pause: remaining wash ticks %0d", n);
    n_cmp++; if (n != 2 || st !== S_DRAIN) begin n_bad++; $display("FAIL pause_resume: ticks %0d state %0d want 2/%0d", n, st, S_DRAIN); end
  endtask

  task automatic test_door_spin();
    apply_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1; door_close = 1'b1;
    start = 1'b1; run_cycle(); start = 1'b0;
    wait_state(S_SPIN, 200, "door_reach_spin");
    n_cmp++; if (motor_on !== 1'b1 || spin_on !== 1'b1) begin n_bad++; $display("FAIL spin_outs: motor %b spin %b want 1/1", motor_on, spin_on); end
    door_close = 1'b0;
    cycle(1'b0);
    n_cmp++; if (st !== S_FAULT) begin n_bad++; $display("FAIL door_fault: got %0d want %0d", st, S_FAULT); end
    n_cmp++; if (outs !== 9'b000100001) begin n_bad++; $display("FAIL door_outs: got %b want %b", outs, 9'b000100001); end
    $display("door_spin: state %0d outs %b", st, outs);
    door_close = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    bit got = 1'b0;
    apply_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1; door_close = 1'b1;
    start = 1'b1; run_cycle(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rinse_cnt == 3'd1) begin got = 1'b1; break; end
      run_cycle();
    end
    drained = 1'b0;
    wait_state(S_DRAIN, 50, "mid_drain_reach");
    n_cmp++; if (!got || rinse_cnt !== 3'd1 || drain_valve_on !== 1'b1) begin
      n_bad++; $display("FAIL drain_setup: rinse %0d valve %b want 1/1", rinse_cnt, drain_valve_on); end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (outs !== 9'd0 || st !== S_IDLE) begin n_bad++; $display("FAIL async_reset: outs %b state %0d want 0/0", outs, st); end
    n_cmp++; if (rinse_cnt !== 3'd0) begin n_bad++; $display("FAIL async_rinse: got %0d want 0", rinse_cnt); end
    $display("mid_drain reset: state %0d outs %b", st, outs);
    drained = 1'b1;
    apply_reset();
  endtask

  task automatic test_no_rinse();
    int w0, d0, s0;
    logic [2:0] e, o;
    logic [2:0] seq [6] = '{S_FILL, S_DET, S_WASH, S_DRAIN, S_SPIN, S_IDLE};
    apply_reset();
    filled = 1'b1; detergent_added = 1'b1; drained = 1'b1; door_close = 1'b1;
    w0 = water0_cnt; d0 = done0_cnt; s0 = soap0_ticks;
    exp_q.delete(); obs0_q.delete();
    foreach (seq[i]) exp_q.push_back(seq[i]);
    start0 = 1'b1; run_cycle(); start0 = 1'b0;
    for (int i = 0; i < 200 && obs0_q.size() < 6; i++) run_cycle();
    repeat (4) run_cycle();
    n_cmp++; if (obs0_q.size() != 6) begin n_bad++; $display("FAIL norinse_len: got %0d want 6", obs0_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs0_q.size() > 0) ? obs0_q.pop_front() : 3'd6;
      $display("norinse: state %0d expected %0d", o, e);
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL norinse_seq: got %0d want %0d", o, e); end
    end
    n_cmp++; if (water0_cnt != w0) begin n_bad++; $display("FAIL norinse_water: got %0d cycles want 0", water0_cnt - w0); end
    n_cmp++; if (soap0_ticks - s0 != 4) begin n_bad++; $display("FAIL norinse_soap: got %0d want 4", soap0_ticks - s0); end
    n_cmp++; if (done0_cnt - d0 != 1) begin n_bad++; $display("FAIL norinse_done: got %0d want 1", done0_cnt - d0); end
    n_cmp++; if (rinse_cnt0 !== 3'd0) begin n_bad++; $display("FAIL norinse_rinse: got %0d want 0", rinse_cnt0); end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; start0 = 1'b0; door_close = 1'b0;
    filled = 1'b0; detergent_added = 1'b0; drained = 1'b0; pause = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_cycle();
    test_fill_timeout();
    test_pause();
    test_door_spin();
    test_reset_mid_drain();
    test_no_rinse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
